// File: rtl/jtkicker_psgsch.sv
// Write scheduler for two PSGs behind one shared data bus.
// CPU writes are queued as {sel,din} and replayed strictly in arrival order.
// Each write is presented to its target PSG for one ISSUE episode that ends on
// that PSG's clock enable. A WAIT phase then gives the chip time to absorb the
// write before the next entry is considered.
module jtkicker_psgsch #(
  parameter int DEPTH = 4
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen1,
  input  logic       cen2,
  input  logic       wr,
  input  logic       sel,
  input  logic [7:0] din,
  input  logic       rdy1,
  input  logic       rdy2,
  output logic [7:0] psg_dout,
  output logic       psg1_cs_n,
  output logic       psg2_cs_n,
  output logic       full,
  output logic       empty,
  output logic       ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Each entry holds {sel, data}
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg, level_next;
  logic          full_reg, empty_reg, ovf_reg;

  state_t        state_reg, state_next;
  logic          tsel_reg;        // target of the write currently in flight
  logic [7:0]    dout_reg;

  logic          push, pop;
  logic [8:0]    head;
  logic          head_rdy;
  logic          tcen, trdy;
  logic          start_issue;

  // Head of queue is read combinationally so IDLE can act on it the cycle it appears
  assign head     = mem[rd_ptr_reg];
  assign head_rdy = head[8] ? rdy2 : rdy1;

  // Target-side enable and ready follow the latched sel, not the live input
  assign tcen = tsel_reg ? cen2 : cen1;
  assign trdy = tsel_reg ? rdy2 : rdy1;

  assign push        = wr && !full_reg;
  assign pop         = (state_reg == ISSUE) && tcen;
  assign start_issue = (state_reg == IDLE) && (state_next == ISSUE);

  // Level after this cycle's push/pop; drives the registered flags
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Queue storage; no reset needed since pointers define validity
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_reg] <= {sel, din};
    end
  end

  // Queue pointers, level and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
      full_reg  <= (level_next == LEVEL_FULL);
      empty_reg <= (level_next == '0);
      if (wr && full_reg) ovf_reg <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!empty_reg && head_rdy) state_next = ISSUE;
      ISSUE:   if (tcen)                   state_next = WAIT;
      // WAIT is entered on a cen pulse, so the next pulse is one full period later
      WAIT:    if (tcen && trdy)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch target and data when an entry is taken from the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      tsel_reg <= 1'b0;
      dout_reg <= 8'h00;
    end else if (start_issue) begin
      tsel_reg <= head[8];
      dout_reg <= head[7:0];
    end
  end

  // FSM outputs: chip select low only in ISSUE, for the latched target
  always_comb begin
    psg1_cs_n = 1'b1;
    psg2_cs_n = 1'b1;
    if (state_reg == ISSUE) begin
      psg1_cs_n = tsel_reg;
      psg2_cs_n = !tsel_reg;
    end
  end

  assign psg_dout = dout_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_jtkicker_psgsch.sv
// Bench for jtkicker_psgsch: directed writes, scoreboard of expected
// chip-select episodes checked by an independent monitor.
module tb_jtkicker_psgsch;

  localparam int DEPTH = 4;

  logic       rst, clk, cen1, cen2, wr, sel, rdy1, rdy2;
  logic [7:0] din;
  logic [7:0] psg_dout;
  logic       psg1_cs_n, psg2_cs_n, full, empty, ovf;

  int         total = 0;
  int         bad = 0;
  int         episodes = 0;
  logic [8:0] sb[$];
  bit         rst_hit = 0;

  jtkicker_psgsch #(.DEPTH(DEPTH)) dut (
    .rst(rst), .clk(clk), .cen1(cen1), .cen2(cen2),
    .wr(wr), .sel(sel), .din(din), .rdy1(rdy1), .rdy2(rdy2),
    .psg_dout(psg_dout), .psg1_cs_n(psg1_cs_n), .psg2_cs_n(psg2_cs_n),
    .full(full), .empty(empty), .ovf(ovf)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // cen1 every 4 clocks, cen2 every 8 clocks
  initial begin
    int cnt;
    cnt  = 0;
    cen1 = 0;
    cen2 = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      cen1 = (cnt % 4 == 0);
      cen2 = (cnt % 8 == 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: detects chip-select episodes and checks them against the scoreboard
  initial begin
    logic       p1, p2, pc1, pc2, tgt;
    logic [7:0] cur;
    logic [8:0] e;
    p1 = 1; p2 = 1; pc1 = 0; pc2 = 0; cur = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_hit) begin
        rst_hit = 0;
      end else begin
        chk("cs_exclusive", {31'd0, psg1_cs_n | psg2_cs_n}, 32'd1);
        if (!p1) chk("cs1_release", {31'd0, psg1_cs_n}, {31'd0, pc1});
        if (!p2) chk("cs2_release", {31'd0, psg2_cs_n}, {31'd0, pc2});
        if ((p1 && !psg1_cs_n) || (p2 && !psg2_cs_n)) begin
          tgt = psg1_cs_n;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_episode: got psg%0d data=%02h expected none",
                     tgt + 1, psg_dout);
          end else begin
            e = sb.pop_front();
            chk("episode_target", {31'd0, tgt}, {31'd0, e[8]});
            chk("episode_data", {24'd0, psg_dout}, {24'd0, e[7:0]});
            cur = e[7:0];
            episodes++;
            $display("episode %0d psg%0d data=%02h", episodes, tgt + 1, psg_dout);
          end
        end else if (!psg1_cs_n || !psg2_cs_n) begin
          chk("dout_stable", {24'd0, psg_dout}, {24'd0, cur});
        end
      end
      p1  = psg1_cs_n;
      p2  = psg2_cs_n;
      pc1 = cen1;
      pc2 = cen2;
    end
  end

  // One write request; expected episodes are queued only for accepted writes
  task automatic do_wr(input logic s, input logic [7:0] d, input bit accept);
    sel = s;
    din = d;
    wr  = 1;
    if (accept) sb.push_back({s, d});
    @(posedge clk);
    #1;
    wr = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(sb.size() == 0 && empty && psg1_cs_n && psg2_cs_n) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_in_time", {31'd0, n < budget}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    int  n, ep0;
    bit  found, quiet;
    rst = 1; wr = 0; sel = 0; din = 8'h00; rdy1 = 1; rdy2 = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs1", {31'd0, psg1_cs_n}, 32'd1);
    chk("rst_cs2", {31'd0, psg2_cs_n}, 32'd1);
    chk("rst_dout", {24'd0, psg_dout}, 32'h00);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 0;
    repeat (2) @(posedge clk);
    #1;

    // Single write: cs low two edges after the write is sampled
    do_wr(0, 8'h9F, 1);
    chk("single_cs1_not_yet", {31'd0, psg1_cs_n}, 32'd1);
    chk("single_not_empty", {31'd0, empty}, 32'd0);
    @(posedge clk);
    #1;
    chk("single_cs1_low", {31'd0, psg1_cs_n}, 32'd0);
    chk("single_cs2_high", {31'd0, psg2_cs_n}, 32'd1);
    chk("single_dout", {24'd0, psg_dout}, 32'h9F);
    wait_idle(200);
    chk("single_dout_hold", {24'd0, psg_dout}, 32'h9F);
    chk("single_empty", {31'd0, empty}, 32'd1);

    // Mixed targets, back to back
    do_wr(0, 8'h80, 1);
    do_wr(1, 8'hA0, 1);
    do_wr(0, 8'h8F, 1);
    wait_idle(400);

    // PSG2 not ready for 50 cycles
    rdy2 = 0;
    do_wr(1, 8'h5A, 1);
    quiet = 1;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (psg2_cs_n !== 1'b1) quiet = 0;
    end
    chk("stall_cs2_high", {31'd0, quiet}, 32'd1);
    rdy2 = 1;
    wait_idle(200);

    // Overflow: four accepted, fifth dropped
    rdy1 = 0;
    ep0  = episodes;
    do_wr(0, 8'h11, 1);
    do_wr(0, 8'h12, 1);
    do_wr(0, 8'h13, 1);
    chk("ovf_not_full_at_3", {31'd0, full}, 32'd0);
    do_wr(0, 8'h14, 1);
    chk("ovf_full_at_4", {31'd0, full}, 32'd1);
    chk("ovf_clear_before_5", {31'd0, ovf}, 32'd0);
    do_wr(0, 8'h15, 0);
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    rdy1 = 1;
    wait_idle(400);
    chk("ovf_issued_count", episodes - ep0, 32'd4);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    chk("ovf_drained_full", {31'd0, full}, 32'd0);

    // Push on the same edge an ISSUE pops, level 2
    rdy1 = 0;
    do_wr(0, 8'h21, 1);
    do_wr(0, 8'h22, 1);
    chk("simul_not_empty", {31'd0, empty}, 32'd0);
    rdy1  = 1;
    found = 0;
    n     = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      if (!psg1_cs_n && cen1) found = 1;
      else n++;
    end
    chk("simul_pop_seen", {31'd0, found}, 32'd1);
    if (found) begin
      #1;
      do_wr(1, 8'h23, 1);
      chk("simul_not_empty_after", {31'd0, empty}, 32'd0);
      chk("simul_not_full_after", {31'd0, full}, 32'd0);
    end
    wait_idle(400);

    // Reset while an ISSUE is in progress with entries queued
    rdy1 = 0;
    do_wr(0, 8'h31, 1);
    do_wr(0, 8'h32, 1);
    do_wr(0, 8'h33, 1);
    rdy1  = 1;
    found = 0;
    n     = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      if (!psg1_cs_n) found = 1;
      else n++;
    end
    chk("rst_mid_issue_seen", {31'd0, found}, 32'd1);
    #1;
    rst     = 1;
    rst_hit = 1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 0;
    chk("rst_mid_cs1", {31'd0, psg1_cs_n}, 32'd1);
    chk("rst_mid_cs2", {31'd0, psg2_cs_n}, 32'd1);
    chk("rst_mid_empty", {31'd0, empty}, 32'd1);
    chk("rst_mid_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_mid_full", {31'd0, full}, 32'd0);
    quiet = 1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (psg1_cs_n !== 1'b1 || psg2_cs_n !== 1'b1) quiet = 0;
    end
    chk("rst_mid_quiet", {31'd0, quiet}, 32'd1);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
